// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: MIPS D-stage stall detection from shadow E/M dst/Tnew state plus mult/div busy counter (clk, reset, IR_D in; stall, md_busy out)
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  output logic        stall,
  output logic        md_busy
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic       rtype;
  logic       addu, subu, jr, mult, multu, div, divu, mfhi, mthi, mflo, mtlo;
  logic       ori, lw, sw, beq, lui, jal;
  logic       alu_r, md_arith, md_class;
  logic       rs_use, rt_use;
  logic [1:0] rs_tuse, rt_tuse;
  logic [4:0] dst_D;
  logic [1:0] tnew_D, mdop_D;
  logic [4:0] dst_E, dst_M;
  logic [1:0] tnew_E, tnew_M, mdop_E;
  logic [3:0] md_cnt;
  logic       stall_rs, stall_rt, stall_md;
  logic       unused;
  assign op     = IR_D[31:26];
  assign rs     = IR_D[25:21];
  assign rt     = IR_D[20:16];
  assign rd     = IR_D[15:11];
  assign funct  = IR_D[5:0];
  assign unused = ^IR_D[10:6];
  assign rtype = op == 6'h00;
  assign addu  = rtype && funct == 6'h21;
  assign subu  = rtype && funct == 6'h23;
  assign jr    = rtype && funct == 6'h08;
  assign mult  = rtype && funct == 6'h18;
  assign multu = rtype && funct == 6'h19;
  assign div   = rtype && funct == 6'h1a;
  assign divu  = rtype && funct == 6'h1b;
  assign mfhi  = rtype && funct == 6'h10;
  assign mthi  = rtype && funct == 6'h11;
  assign mflo  = rtype && funct == 6'h12;
  assign mtlo  = rtype && funct == 6'h13;
  assign ori   = op == 6'h0d;
  assign lw    = op == 6'h23;
  assign sw    = op == 6'h2b;
  assign beq   = op == 6'h04;
  assign lui   = op == 6'h0f;
  assign jal   = op == 6'h03;
  assign alu_r    = addu || subu;
  assign md_arith = mult || multu || div || divu;
  assign md_class = md_arith || mfhi || mflo || mthi || mtlo;
  // Tuse: 0 = needed in D (branch compare), 1 = needed in E, 2 = needed in M (store data)
  assign rs_use  = beq || jr || alu_r || ori || lw || sw || md_arith || mthi || mtlo;
  assign rs_tuse = (beq || jr) ? 2'd0 : 2'd1;
  assign rt_use  = beq || alu_r || md_arith || sw;
  assign rt_tuse = beq ? 2'd0 : sw ? 2'd2 : 2'd1;
  always_comb begin
    dst_D  = (alu_r || mfhi || mflo) ? rd : (ori || lui || lw) ? rt : jal ? 5'd31 : 5'd0;
    tnew_D = lw ? 2'd2 : (alu_r || mfhi || mflo || ori || lui) ? 2'd1 : 2'd0;
    mdop_D = (mult || multu) ? 2'd1 : (div || divu) ? 2'd2 : 2'd0;
  end
  // dst of 0 marks an empty slot, so the reg-0 guard also covers bubbles
  assign stall_rs = rs_use && rs != 5'd0 &&
                    ((rs == dst_E && rs_tuse < tnew_E) || (rs == dst_M && rs_tuse < tnew_M));
  assign stall_rt = rt_use && rt != 5'd0 &&
                    ((rt == dst_E && rt_tuse < tnew_E) || (rt == dst_M && rt_tuse < tnew_M));
  assign stall_md = md_class && (mdop_E != 2'd0 || md_cnt != 4'd0);
  assign stall    = stall_rs || stall_rt || stall_md;
  assign md_busy  = md_cnt != 4'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_E  <= 5'd0;
      tnew_E <= 2'd0;
      mdop_E <= 2'd0;
      dst_M  <= 5'd0;
      tnew_M <= 2'd0;
      md_cnt <= 4'd0;
    end else begin
      dst_E  <= stall ? 5'd0 : dst_D;
      tnew_E <= stall ? 2'd0 : tnew_D;
      mdop_E <= stall ? 2'd0 : mdop_D;
      dst_M  <= dst_E;
      tnew_M <= tnew_E == 2'd0 ? 2'd0 : tnew_E - 2'd1;
      // an op leaving E reloads the counter even while a bubble enters behind it
      md_cnt <= mdop_E == 2'd1 ? 4'(MULT_CYCLES) :
                mdop_E == 2'd2 ? 4'(DIV_CYCLES) :
                md_cnt != 4'd0 ? md_cnt - 4'd1 : 4'd0;
    end
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Hazard detection unit for the 5-stage MIPS pipeline. It produces the `stall` signal that freezes PC and IF/ID and clears ID/EX into a bubble.
- It keeps a shadow copy of the E- and M-stage destination/Tnew state, updated under the same stall/bubble rule as the ID/EX register, so hazards are judged from the unit's own state.
- It also owns the mult/div busy counter that serialises HI/LO accesses.

Parameters:
- `MULT_CYCLES`, 5, busy cycles after mult/multu leaves E.
- `DIV_CYCLES`, 10, busy cycles after div/divu leaves E.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `IR_D`  in  32  instruction currently in the D stage
- `stall`  out  1  1 = hold PC/IF_ID and clear ID_EX this edge
- `md_busy`  out  1  mult/div unit still computing (counter != 0)

Behaviour:
- Decode (combinational, applied to `IR_D`):
  - R-type (op 0) funct codes: addu 21h, subu 23h, jr 08h, mult 18h, multu 19h, div 1Ah, divu 1Bh, mfhi 10h, mthi 11h, mflo 12h, mtlo 13h.
  - I/J-type op codes: ori 0Dh, lw 23h, sw 2Bh, beq 04h, lui 0Fh, jal 03h.
  - Any other encoding, including 0: no write, no read, not md-class.
- Tuse per source register:
  - rs, Tuse 0: beq, jr.
  - rs, Tuse 1: addu, subu, ori, lw, sw, mult/multu/div/divu, mthi, mtlo.
  - rt, Tuse 0: beq.
  - rt, Tuse 1: addu, subu, mult/multu/div/divu.
  - rt, Tuse 2: sw.
  - All other fields: no use.
- Destination and Tnew at E entry:
  - addu, subu, mfhi, mflo: dst = rd, Tnew 1.
  - ori, lui: dst = rt, Tnew 1.
  - lw: dst = rt, Tnew 2.
  - jal: dst = 31, Tnew 0.
  - Everything else: dst = 0.
- State registers:
  - E slot: `dst_E`[4:0], `tnew_E`[1:0], `mdop_E`[1:0] (0 none, 1 mult-class, 2 div-class).
  - M slot: `dst_M`, `tnew_M`.
  - `md_cnt`[3:0].
- Each posedge:
  - `reset`: all state 0.
  - Else E slot: if `stall`, load 0 (bubble); otherwise load the decoded `IR_D`.
  - Else M slot: M <= E with `tnew` = `tnew_E` - 1, saturating at 0. The M slot advances regardless of `stall`.
  - Else `md_cnt`: `mdop_E` = 1 loads `MULT_CYCLES`; `mdop_E` = 2 loads `DIV_CYCLES`; otherwise, if nonzero, decrement.
- `stall` (combinational) is the OR of:
  - (a) D reads rs, rs != 0, and (rs == `dst_E` and Tuse_rs < `tnew_E`, or rs == `dst_M` and Tuse_rs < `tnew_M`).
  - (b) The same condition as (a) for rt.
  - (c) D is md-class (mult*, div*, mfhi, mflo, mthi, mtlo) and (`mdop_E` != 0 or `md_cnt` != 0).
- Register 0 never causes a hazard.
- W-stage results are resolved by forwarding and never stall.
- `md_busy` = (`md_cnt` != 0).
- Reset values: `stall` = 0 (with a non-hazard `IR_D`), `md_busy` = 0.
- Reset mid-operation aborts the counter immediately; there is no pending busy after reset.
- Simultaneous events:
  - A bubble entering E while a mult leaves E still loads the counter.
  - A load of `md_cnt` takes priority over its decrement.
- Latency to resolution:
  - lw → ALU-consumer: 1 stall cycle.
  - lw → beq/jr: 2 stall cycles.
  - ALU → beq/jr: 1 stall cycle.
  - mult → md-class: 1 + `MULT_CYCLES` stall cycles.
  - div → md-class: 1 + `DIV_CYCLES` stall cycles.

Test Plan:
1. Clock in lw $1,0($0), then hold `IR_D` = addu $2,$1,$3 → `stall` = 1 for exactly 1 cycle, then 0 (`tnew_M` = 1 is not greater than Tuse 1).
2. lw $1 then beq $1,$2 → `stall` = 1 for 2 cycles. addu $1 then beq $1,$2 → `stall` = 1 for 1 cycle. addu $1 then sw $1,0($2) (rt use, Tuse 2) → `stall` = 0.
3. lw $0,0($1) then addu $2,$0,$0 → `stall` stays 0. jal then jr $31 → `stall` stays 0 (Tnew 0).
4. mult $1,$2 then `IR_D` held at mfhi $3 → `stall` = 1 for 6 consecutive cycles, `md_busy` high for the last 5 of them, mfhi enters E on cycle 7. With div the stall lasts 11 cycles.
5. div issued, assert `reset` when `md_cnt` = 7 → after that edge `md_busy` = 0, all slots empty, and `stall` = 0 for `IR_D` = mflo.
6. Back-to-back independent instructions (ori $1; addu $4,$5,$6; sw $7,0($8)) → `stall` never asserted, `md_busy` = 0 throughout.
